// File: rtl/gray_counter_param.sv
// gray_counter_param: parametrised up/down Gray-code counter.
//
// Keeps a binary count and a Gray count in two registers that are both loaded
// from the same next-state binary value, so count_gray always equals
// count_bin ^ (count_bin >> 1) with no skew between them.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   SATURATE 0 = wrap at the terminal value, 1 = hold at the terminal value
//   RST_VAL  binary value loaded on reset (< 2**WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         count enable
//   up         direction, 1 = increment, 0 = decrement
//   ld         synchronous load (overrides en)
//   data_in    load value
//   count_bin  registered binary count
//   count_gray registered Gray count
//   tc         terminal count (combinational from the registered count)
//   wrap       registered one-cycle pulse after a wrap-around
//
// Optional feature, macro GRAY_CNT_GRAY_LOAD_EN: when defined, data_in is a
// Gray code and is converted to binary on load; otherwise data_in is binary.

module gray_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RstBin  = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RstGray = RstBin ^ (RstBin >> 1);
  localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);
  localparam logic [WIDTH-1:0] AllOnes = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] term_val;
  logic             at_term;

`ifdef GRAY_CNT_GRAY_LOAD_EN
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    load_bin = '0;
    load_bin[WIDTH-1] = data_in[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ data_in[i];
    end
  end
`else
  assign load_bin = data_in;
`endif

  assign term_val = up ? AllOnes : '0;
  assign at_term  = (bin_q == term_val);
  assign tc       = en & ~ld & at_term;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (ld) begin
      bin_d = load_bin;
    end else if (en) begin
      if (at_term && (SATURATE != 0)) begin
        bin_d = bin_q;
      end else begin
        bin_d  = up ? (bin_q + OneVal) : (bin_q - OneVal);
        wrap_d = at_term;
      end
    end
    // Gray is always derived from the next binary value, never the current one.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RstBin;
      gray_q <= RstGray;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign count_bin  = bin_q;
  assign count_gray = gray_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (4-bit wrap, 4-bit saturate,
// 8-bit wrap with nonzero reset value) driven by shared controls and checked
// against an arithmetic reference model every cycle.

module tb_gray_counter_param;

  logic       clk;
  logic       rst, ld, en, up;
  logic [7:0] din;

  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic [7:0] bin_c, gray_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int w_of[3] = '{4, 4, 8};
  int s_of[3] = '{0, 1, 0};
  int r_of[3] = '{0, 0, 90};
  int m_bin[3];
  int m_wrap[3];

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .data_in(din[3:0]),
    .count_bin(bin_a), .count_gray(gray_a), .tc(tc_a), .wrap(wrap_a)
  );

  gray_counter_param #(.WIDTH(4), .SATURATE(1), .RST_VAL(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .data_in(din[3:0]),
    .count_bin(bin_b), .count_gray(gray_b), .tc(tc_b), .wrap(wrap_b)
  );

  gray_counter_param #(.WIDTH(8), .SATURATE(0), .RST_VAL(90)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .data_in(din),
    .count_bin(bin_c), .count_gray(gray_c), .tc(tc_c), .wrap(wrap_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_bin(input int k);
    case (k)
      0:       return {28'b0, bin_a};
      1:       return {28'b0, bin_b};
      default: return {24'b0, bin_c};
    endcase
  endfunction

  function automatic logic [31:0] get_gray(input int k);
    case (k)
      0:       return {28'b0, gray_a};
      1:       return {28'b0, gray_b};
      default: return {24'b0, gray_c};
    endcase
  endfunction

  function automatic logic get_tc(input int k);
    case (k)
      0:       return tc_a;
      1:       return tc_b;
      default: return tc_c;
    endcase
  endfunction

  function automatic logic get_wrap(input int k);
    case (k)
      0:       return wrap_a;
      1:       return wrap_b;
      default: return wrap_c;
    endcase
  endfunction

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Value the counter takes on a load, in binary.
  function automatic int load_value(input int d, input int w);
    int v;
    v = d % (1 << w);
`ifdef GRAY_CNT_GRAY_LOAD_EN
    // Prefix XOR from the MSB down via doubling shifts.
    for (int s = 1; s < 32; s = s * 2) v = v ^ (v >> s);
`endif
    return v;
  endfunction

  task automatic cycle(input logic r, input logic l, input logic e, input logic u,
                       input logic [7:0] d);
    int prev_gray[3];
    int modulus, step, nxt;
    rst = r; ld = l; en = e; up = u; din = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      modulus = 1 << w_of[k];
      check($sformatf("tc[%0d]", k), {31'b0, get_tc(k)},
            {31'b0, e && !l && (m_bin[k] == (u ? modulus - 1 : 0))});
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      prev_gray[k] = get_gray(k);
      modulus = 1 << w_of[k];
      if (r) begin
        m_bin[k] = r_of[k]; m_wrap[k] = 0;
      end else if (l) begin
        m_bin[k] = load_value(int'(d), w_of[k]); m_wrap[k] = 0;
      end else if (e) begin
        step = u ? 1 : -1;
        nxt  = m_bin[k] + step;
        if (nxt < 0 || nxt >= modulus) begin
          // Crossing the range boundary: wrap or stay put.
          if (s_of[k] != 0) begin
            m_wrap[k] = 0;
          end else begin
            m_bin[k] = (nxt + modulus) % modulus; m_wrap[k] = 1;
          end
        end else begin
          m_bin[k] = nxt; m_wrap[k] = 0;
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bin[%0d]", k), get_bin(k), m_bin[k]);
      check($sformatf("gray[%0d]", k), get_gray(k), to_gray(m_bin[k]));
      check($sformatf("wrap[%0d]", k), {31'b0, get_wrap(k)}, m_wrap[k]);
      if (!r && !l && e && (get_gray(k) != prev_gray[k]))
        check($sformatf("hamming[%0d]", k), $countones(get_gray(k) ^ prev_gray[k]), 1);
    end
    @(negedge clk);
  endtask

  logic [7:0] ld9;

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; din = '0;
    for (int k = 0; k < 3; k++) begin m_bin[k] = 0; m_wrap[k] = 0; end
`ifdef GRAY_CNT_GRAY_LOAD_EN
    ld9 = 8'h0D;
`else
    ld9 = 8'h09;
`endif
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 1, 8'h00);
    check("rst_bin_a", {28'b0, bin_a}, 0);
    check("rst_gray_c", {24'b0, gray_c}, 32'h77);

    // Full up-count sweep: A wraps, B saturates at 15
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 1, 8'h00);
    check("sweep_bin_a", {28'b0, bin_a}, 0);
    check("sweep_wrap_a", {31'b0, wrap_a}, 1);
    check("sat_gray_b", {28'b0, gray_b}, 32'b1000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 8'h00);
    check("sat_hold_b", {28'b0, bin_b}, 15);

    // Load beats count on the same edge
    cycle(0, 1, 1, 1, ld9);
    check("ld_bin_a", {28'b0, bin_a}, 9);
    check("ld_gray_a", {28'b0, gray_a}, 32'b1101);

    // Down-count through zero
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 8'h00);
    check("down_bin_a", {28'b0, bin_a}, 15);
    check("down_wrap_a", {31'b0, wrap_a}, 1);
    check("down_sat_b", {28'b0, bin_b}, 0);

    // Load then one up step
    cycle(0, 1, 0, 1, ld9);
    cycle(0, 0, 1, 1, 8'h00);
    check("step_bin_a", {28'b0, bin_a}, 10);
    check("step_gray_a", {28'b0, gray_a}, 32'b1111);

    // Reset overrides load mid-count
    cycle(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 8'h00);
    cycle(1, 1, 1, 1, 8'h03);
    check("rst_ovr_bin_a", {28'b0, bin_a}, 0);
    check("rst_ovr_bin_c", {24'b0, bin_c}, 90);

    // Randomised run
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0),
            ($urandom_range(3) != 0), 1'($urandom_range(1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised up/down Gray-code counter with synchronous load, count enable, and wrap or saturate mode.
- Keeps an internal binary count and drives registered binary and Gray outputs that are always cycle-aligned; the Gray output never lags the binary output by a cycle.
- Intended for FIFO pointers, pointers that cross clock domains, and position/sequence counters where each step must change exactly one output bit.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value.
- RST_VAL, 0, binary value loaded on reset; must be below 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- ld  input  1  synchronous load.
- data_in  input  WIDTH  load value; binary unless the optional feature is enabled.
- count_bin  output  WIDTH  registered binary count.
- count_gray  output  WIDTH  registered Gray count.
- tc  output  1  terminal count, combinational from the registered count.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Single clock, clk. Reset is synchronous, active-high, on port rst. All state changes occur on the rising edge of clk.
- Priority per edge: rst > ld > en > hold.
- Reset:
  - count_bin <= RST_VAL.
  - count_gray <= RST_VAL ^ (RST_VAL >> 1).
  - wrap <= 0.
  - Reset asserted mid-count overrides any ld or en on that same edge.
- Invariant: count_gray == count_bin ^ (count_bin >> 1) on every cycle.
  - Both registers load from the same next-state binary value on the same edge.
  - The Gray register must not be computed from the previous binary value, so there is no one-cycle skew.
- Load (ld=1):
  - count_bin <= data_in; count_gray <= the Gray encoding of data_in.
  - wrap <= 0.
  - en and up are ignored on that edge. A load may change several Gray bits at once.
- Count (en=1, ld=0):
  - up=1: next = count_bin + 1, modulo 2**WIDTH.
  - up=0: next = count_bin - 1, modulo 2**WIDTH.
  - When counting, exactly one count_gray bit changes per edge.
- Hold (en=0, ld=0): both counts unchanged; wrap <= 0.
- Terminal value:
  - all ones when up=1; zero when up=0.
  - tc = en & ~ld & (count_bin == terminal value for the current up).
- At the terminal value with a count request:
  - SATURATE=0: the counter wraps (all ones -> 0 up; 0 -> all ones down) and wrap <= 1 for exactly one cycle. Otherwise wrap <= 0.
  - SATURATE=1: the counter holds, wrap stays 0, and tc stays high while the request persists.
- Direction change: up may toggle on any cycle; the next step follows the new direction immediately, with no extra latency.
- Latency: one clock from a qualifying rst/ld/en edge to updated outputs. tc follows the registered count combinationally.

Optional Feature:
- Macro: GRAY_CNT_GRAY_LOAD_EN.
- Defined:
  - data_in is interpreted as a Gray code.
  - Load converts it to binary: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
  - count_gray <= data_in; count_bin <= the converted value.
  - Use this to reload a counter from a Gray pointer that came from another domain.
- Undefined: data_in is binary, and Gray is derived from it as described under Behaviour.

Test Plan:
- WIDTH=4, rst=1 then en=1, up=1 for 16 clocks -> count_bin steps 0,1,...,15,0; count_gray steps 0000,0001,0011,0010,...,1000,0000; Hamming distance exactly 1 each step; wrap high only on the cycle after 15->0.
- Count reaches 15 with up=1, en=1, SATURATE=1 -> held at 15 (gray 1000); tc=1 for as long as en stays high; wrap=0.
- ld=1, data_in=4'd9 with en=1 on the same edge -> count_bin=9, count_gray=1101, no increment; then up=0 for 10 clocks -> 8,7,...,0,15 with wrap pulsed after 0->15.
- Mid-count at 6: assert rst together with ld=1 and data_in=3 -> count_bin=RST_VAL=0, count_gray=0000, wrap=0.
- GRAY_CNT_GRAY_LOAD_EN defined: ld with data_in=4'b1101 -> count_gray=1101, count_bin=9; next up-count -> count_gray=1111, count_bin=10.
- WIDTH=8, random en/up/ld for 10k cycles -> scoreboard confirms the Gray/binary invariant every cycle and single-bit Gray changes on every non-load step.
